// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv
// Purpose  : Single-cycle integer ALU with multi-cycle radix-2 multiplier and
//            restoring divider sharing one request/response handshake.
// Ports    : CLK100MHZ    - clock, rising edge
//            RESET        - synchronous active-high reset
//            VALID_IN     - request present; taken when READY=1
//            A, B, OPCODE - operands / operation select (A also = shift amount)
//            READY        - request accepted this cycle
//            VALID_OUT    - one-cycle pulse: RESULT/flags/HI/LO updated
//            RESULT       - registered result (LO for multiply/divide)
//            ZERO         - RESULT == 0
//            OVERFLOW     - signed overflow of ADD/SUB
//            DIV_BY_ZERO  - last divide had B == 0
//            HI, LO       - multiply/divide result registers
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
  parameter int lenghtIN = 32,
  parameter int lenghtOP = 4
) (
  input  logic                CLK100MHZ,
  input  logic                RESET,
  input  logic                VALID_IN,
  input  logic [lenghtIN-1:0] A,
  input  logic [lenghtIN-1:0] B,
  input  logic [lenghtOP-1:0] OPCODE,
  output logic                READY,
  output logic                VALID_OUT,
  output logic [lenghtIN-1:0] RESULT,
  output logic                ZERO,
  output logic                OVERFLOW,
  output logic                DIV_BY_ZERO,
  output logic [lenghtIN-1:0] HI,
  output logic [lenghtIN-1:0] LO
);

  localparam int c_W   = lenghtIN;
  localparam int c_MSB = lenghtIN - 1;
  localparam int c_SHW = $clog2(lenghtIN);
  localparam logic [c_SHW-1:0] c_CNT_LAST = c_SHW'(lenghtIN - 1);

  localparam logic [lenghtOP-1:0] c_OP_SLL   = lenghtOP'(0);
  localparam logic [lenghtOP-1:0] c_OP_SRL   = lenghtOP'(1);
  localparam logic [lenghtOP-1:0] c_OP_SRA   = lenghtOP'(2);
  localparam logic [lenghtOP-1:0] c_OP_ADD   = lenghtOP'(3);
  localparam logic [lenghtOP-1:0] c_OP_SUB   = lenghtOP'(4);
  localparam logic [lenghtOP-1:0] c_OP_AND   = lenghtOP'(5);
  localparam logic [lenghtOP-1:0] c_OP_OR    = lenghtOP'(6);
  localparam logic [lenghtOP-1:0] c_OP_XOR   = lenghtOP'(7);
  localparam logic [lenghtOP-1:0] c_OP_NOR   = lenghtOP'(8);
  localparam logic [lenghtOP-1:0] c_OP_SLT   = lenghtOP'(9);
  localparam logic [lenghtOP-1:0] c_OP_SLTU  = lenghtOP'(10);
  localparam logic [lenghtOP-1:0] c_OP_MULTU = lenghtOP'(11);
  localparam logic [lenghtOP-1:0] c_OP_MULT  = lenghtOP'(12);
  localparam logic [lenghtOP-1:0] c_OP_DIVU  = lenghtOP'(13);
  localparam logic [lenghtOP-1:0] c_OP_DIV   = lenghtOP'(14);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Iterative datapath state
  logic [c_W-1:0]   r_acc_hi;   // partial product high half / partial remainder
  logic [c_W-1:0]   r_acc_lo;   // multiplier bits / dividend-then-quotient bits
  logic [c_W-1:0]   r_opnd;     // multiplicand / divisor magnitude
  logic [c_SHW-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_q;    // negate product / quotient at the end
  logic             r_neg_r;    // negate remainder at the end
  logic             r_dbz;

  // Request decode
  logic             w_accept;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_is_multi;
  logic             w_signed_op;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [c_W-1:0]   w_a_mag;
  logic [c_W-1:0]   w_b_mag;
  logic             w_last;

  // Single-cycle ALU
  logic [c_SHW-1:0] w_shamt;
  logic [c_W-1:0]   w_sum;
  logic [c_W-1:0]   w_diff;
  logic [c_W-1:0]   w_alu;
  logic             w_alu_ovf;

  // Iteration step and final sign fix-up
  logic [c_W:0]     w_mul_sum;
  logic [c_W-1:0]   w_mul_hi;
  logic [c_W-1:0]   w_mul_lo;
  logic [c_W:0]     w_div_sh;
  logic             w_div_ge;
  logic [c_W-1:0]   w_div_diff;
  logic [c_W-1:0]   w_div_hi;
  logic [c_W-1:0]   w_div_lo;
  logic [c_W-1:0]   w_step_hi;
  logic [c_W-1:0]   w_step_lo;
  logic [2*c_W-1:0] w_prod;
  logic [2*c_W-1:0] w_prod_fix;
  logic [c_W-1:0]   w_fin_hi;
  logic [c_W-1:0]   w_fin_lo;

  // READY is forced low while RESET is high so nothing is accepted then.
  assign READY       = !RESET && (r_state != S_BUSY);
  assign w_accept    = VALID_IN && READY;

  assign w_is_mul    = (OPCODE == c_OP_MULTU) || (OPCODE == c_OP_MULT);
  assign w_is_div    = (OPCODE == c_OP_DIVU)  || (OPCODE == c_OP_DIV);
  assign w_is_multi  = w_is_mul || w_is_div;
  assign w_signed_op = (OPCODE == c_OP_MULT)  || (OPCODE == c_OP_DIV);
  assign w_a_neg     = w_signed_op && A[c_MSB];
  assign w_b_neg     = w_signed_op && B[c_MSB];
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  assign w_a_mag     = w_a_neg ? (-A) : A;
  assign w_b_mag     = w_b_neg ? (-B) : B;
  assign w_last      = (r_state == S_BUSY) && (r_cnt == c_CNT_LAST);

  // ---------------------------------------------------------------- ALU ----
  assign w_shamt = A[c_SHW-1:0];
  assign w_sum   = A + B;
  assign w_diff  = A - B;

  always_comb begin
    w_alu     = '0;
    w_alu_ovf = 1'b0;
    case (OPCODE)
      c_OP_SLL:  w_alu = B << w_shamt;
      c_OP_SRL:  w_alu = B >> w_shamt;
      c_OP_SRA:  w_alu = $unsigned($signed(B) >>> w_shamt);
      c_OP_ADD: begin
        w_alu     = w_sum;
        w_alu_ovf = (A[c_MSB] == B[c_MSB]) && (w_sum[c_MSB] != A[c_MSB]);
      end
      c_OP_SUB: begin
        w_alu     = w_diff;
        w_alu_ovf = (A[c_MSB] != B[c_MSB]) && (w_diff[c_MSB] != A[c_MSB]);
      end
      c_OP_AND:  w_alu = A & B;
      c_OP_OR:   w_alu = A | B;
      c_OP_XOR:  w_alu = A ^ B;
      c_OP_NOR:  w_alu = ~(A | B);
      c_OP_SLT:  w_alu = {{(c_W-1){1'b0}}, ($signed(A) < $signed(B))};
      c_OP_SLTU: w_alu = {{(c_W-1){1'b0}}, (A < B)};
      default:   w_alu = '0;  // reserved and multi-cycle opcodes
    endcase
  end

  // ------------------------------------------------------ iteration step ----
  // Shift-add: add the multiplicand when the current multiplier LSB is set,
  // then shift {carry, hi, lo} right by one.
  assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : {(c_W+1){1'b0}});
  assign w_mul_hi   = w_mul_sum[c_W:1];
  assign w_mul_lo   = {w_mul_sum[0], r_acc_lo[c_W-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder and keep
  // the subtraction only when it does not go negative. A zero divisor yields
  // an all-ones quotient and leaves |A| in the remainder.
  assign w_div_sh   = {r_acc_hi, r_acc_lo[c_W-1]};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_opnd});
  assign w_div_diff = w_div_sh[c_W-1:0] - r_opnd;
  assign w_div_hi   = w_div_ge ? w_div_diff : w_div_sh[c_W-1:0];
  assign w_div_lo   = {r_acc_lo[c_W-2:0], w_div_ge};

  assign w_step_hi  = r_is_div ? w_div_hi : w_mul_hi;
  assign w_step_lo  = r_is_div ? w_div_lo : w_mul_lo;

  assign w_prod     = {w_step_hi, w_step_lo};
  assign w_prod_fix = r_neg_q ? (-w_prod) : w_prod;

  assign w_fin_hi   = r_is_div ? (r_neg_r ? (-w_step_hi) : w_step_hi)
                               : w_prod_fix[2*c_W-1:c_W];
  assign w_fin_lo   = r_is_div ? (r_dbz ? {c_W{1'b1}} : (r_neg_q ? (-w_step_lo) : w_step_lo))
                               : w_prod_fix[c_W-1:0];

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_state_nxt = (w_accept && w_is_multi) ? S_BUSY : S_IDLE;
      S_BUSY:         if (w_last) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath ----
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      VALID_OUT   <= 1'b0;
      RESULT      <= '0;
      ZERO        <= 1'b0;
      OVERFLOW    <= 1'b0;
      DIV_BY_ZERO <= 1'b0;
      HI          <= '0;
      LO          <= '0;
      r_acc_hi    <= '0;
      r_acc_lo    <= '0;
      r_opnd      <= '0;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      VALID_OUT <= 1'b0;
      if (w_accept) begin
        if (w_is_multi) begin
          r_cnt    <= '0;
          r_acc_hi <= '0;
          r_is_div <= w_is_div;
          if (w_is_div) begin
            r_acc_lo <= w_a_mag;
            r_opnd   <= w_b_mag;
            r_dbz    <= (B == '0);
            r_neg_q  <= (B != '0) && (w_a_neg ^ w_b_neg);
            r_neg_r  <= w_a_neg;
          end else begin
            r_acc_lo <= w_b_mag;
            r_opnd   <= w_a_mag;
            r_dbz    <= 1'b0;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= 1'b0;
          end
        end else begin
          RESULT      <= w_alu;
          ZERO        <= (w_alu == '0);
          OVERFLOW    <= w_alu_ovf;
          DIV_BY_ZERO <= 1'b0;
          VALID_OUT   <= 1'b1;
        end
      end else if (r_state == S_BUSY) begin
        r_acc_hi <= w_step_hi;
        r_acc_lo <= w_step_lo;
        r_cnt    <= r_cnt + 1'b1;
        // Architectural registers only change on the final iteration, so an
        // aborted operation never exposes a partial value.
        if (w_last) begin
          HI          <= w_fin_hi;
          LO          <= w_fin_lo;
          RESULT      <= w_fin_lo;
          ZERO        <= (w_fin_lo == '0);
          OVERFLOW    <= 1'b0;
          DIV_BY_ZERO <= r_dbz;
          VALID_OUT   <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv
// Purpose  : Self-checking bench for alu_muldiv (32-bit configuration).
//            Expected results come from a behavioural model using native
//            arithmetic and are queued when a request is driven; a monitor
//            pops and compares on every VALID_OUT. Scenario tasks add inline
//            timing, handshake and reset checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   opcode;
  logic         ready;
  logic         vout;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         dbz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         ov;
    logic         dbz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         scb[$];
  exp_t         mon_e;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  alu_muldiv #(.lenghtIN(W), .lenghtOP(4)) dut (
    .CLK100MHZ  (clk),
    .RESET      (rst),
    .VALID_IN   (valid_in),
    .A          (a),
    .B          (b),
    .OPCODE     (opcode),
    .READY      (ready),
    .VALID_OUT  (vout),
    .RESULT     (result),
    .ZERO       (zero),
    .OVERFLOW   (ovf),
    .DIV_BY_ZERO(dbz),
    .HI         (hi),
    .LO         (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Behavioural reference; keeps its own copy of HI/LO.
  task automatic push_exp(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t                e;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sbv;
    logic signed [63:0]  xa;
    logic signed [63:0]  xb;
    logic signed [63:0]  sp;
    logic [63:0]         p;
    sa  = av;
    sbv = bv;
    e.res = '0; e.z = 1'b0; e.ov = 1'b0; e.dbz = 1'b0; e.hi = m_hi; e.lo = m_lo;
    case (op)
      4'd0:  e.res = bv << av[4:0];
      4'd1:  e.res = bv >> av[4:0];
      4'd2:  e.res = sbv >>> av[4:0];
      4'd3:  begin e.res = av + bv; e.ov = (av[31] == bv[31]) && (e.res[31] != av[31]); end
      4'd4:  begin e.res = av - bv; e.ov = (av[31] != bv[31]) && (e.res[31] != av[31]); end
      4'd5:  e.res = av & bv;
      4'd6:  e.res = av | bv;
      4'd7:  e.res = av ^ bv;
      4'd8:  e.res = ~(av | bv);
      4'd9:  e.res = (sa < sbv) ? 32'd1 : 32'd0;
      4'd10: e.res = (av < bv) ? 32'd1 : 32'd0;
      4'd11: begin p = {32'd0, av} * {32'd0, bv}; e.hi = p[63:32]; e.lo = p[31:0]; end
      4'd12: begin xa = sa; xb = sbv; sp = xa * xb; e.hi = sp[63:32]; e.lo = sp[31:0]; end
      4'd13: begin
        if (bv == 0) begin e.lo = '1; e.hi = av; e.dbz = 1'b1; end
        else begin e.lo = av / bv; e.hi = av % bv; end
      end
      4'd14: begin
        if (bv == 0) begin e.lo = '1; e.hi = av; e.dbz = 1'b1; end
        else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin e.lo = av; e.hi = '0; end
        else begin e.lo = sa / sbv; e.hi = sa % sbv; end
      end
      default: e.res = '0;
    endcase
    if (op >= 4'd11 && op <= 4'd14) begin
      e.res = e.lo;
      m_hi  = e.hi;
      m_lo  = e.lo;
    end
    e.z = (e.res == 0);
    scb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    push_exp(op, av, bv);
    valid_in = 1'b1; opcode = op; a = av; b = bv;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  // Number of falling edges until VALID_OUT is seen; -1 when the budget expires.
  task automatic wait_vo(output int n);
    n = -1;
    for (int i = 1; i <= 100 && n < 0; i++) begin
      @(negedge clk);
      if (vout === 1'b1) n = i;
    end
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (vout === 1'b1) begin
        n_cmp = n_cmp + 1;
        if (scb.size() == 0) begin
          n_bad = n_bad + 1;
          $display("FAIL unexpected_valid_out: got VALID_OUT=1 RESULT=%h, required no output", result);
        end else begin
          mon_e = scb.pop_front();
          if ({result, zero, ovf, dbz, hi, lo} !== {mon_e.res, mon_e.z, mon_e.ov, mon_e.dbz, mon_e.hi, mon_e.lo}) begin
            n_bad = n_bad + 1;
            $display("FAIL scoreboard: got RES=%h Z=%b OV=%b DBZ=%b HI=%h LO=%h, required RES=%h Z=%b OV=%b DBZ=%b HI=%h LO=%h",
                     result, zero, ovf, dbz, hi, lo, mon_e.res, mon_e.z, mon_e.ov, mon_e.dbz, mon_e.hi, mon_e.lo);
          end
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1; valid_in = 1'b1; opcode = 4'd3; a = 32'd1; b = 32'd1;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b required 0", ready); end
    n_cmp++;
    if ({vout, result, zero, ovf, dbz, hi, lo} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got VO=%b RES=%h HI=%h LO=%h flags=%b%b%b required all 0", vout, result, hi, lo, zero, ovf, dbz);
    end
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || vout !== 1'b0) begin n_bad++; $display("FAIL ready_after_reset: got READY=%b VO=%b required 1 0", ready, vout); end
  endtask

  task automatic test_shift;
    issue(4'd0, 32'd3, 32'h15);
    @(negedge clk);
    n_cmp++;
    if (vout !== 1'b1 || result !== 32'hA8) begin n_bad++; $display("FAIL sll_latency: got VO=%b RES=%h required 1 000000a8", vout, result); end
    issue(4'd2, 32'd2, 32'hFFFF_FFEB);
    @(negedge clk);
    n_cmp++;
    if (vout !== 1'b1 || result !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL sra: got VO=%b RES=%h required 1 fffffffa", vout, result); end
    @(negedge clk);
    n_cmp++;
    if (vout !== 1'b0 || result !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL single_pulse_hold: got VO=%b RES=%h required 0 fffffffa", vout, result); end
  endtask

  task automatic test_addsub;
    push_exp(4'd3, 32'h7FFF_FFFF, 32'd1);
    push_exp(4'd4, 32'hFF, 32'hFF);
    valid_in = 1'b1; opcode = 4'd3; a = 32'h7FFF_FFFF; b = 32'd1;
    @(posedge clk); #1;
    opcode = 4'd4; a = 32'hFF; b = 32'hFF;
    @(negedge clk);
    n_cmp++;
    if (vout !== 1'b1 || result !== 32'h8000_0000 || ovf !== 1'b1) begin
      n_bad++; $display("FAIL add_overflow: got VO=%b RES=%h OV=%b required 1 80000000 1", vout, result, ovf);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (vout !== 1'b1 || result !== 32'd0 || zero !== 1'b1 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL sub_back_to_back: got VO=%b RES=%h Z=%b OV=%b required 1 0 1 0", vout, result, zero, ovf);
    end
  endtask

  task automatic test_mult;
    int n;
    int busy;
    n = -1; busy = 0;
    issue(4'd12, 32'hFFFF_FFFD, 32'd5);
    for (int i = 1; i <= 100 && n < 0; i++) begin
      @(negedge clk);
      if (ready === 1'b0) busy++;
      if (vout === 1'b1) n = i;
    end
    n_cmp++;
    if (n != 33) begin n_bad++; $display("FAIL mult_latency: got %0d required 33", n); end
    n_cmp++;
    if (busy != 32) begin n_bad++; $display("FAIL mult_ready_low: got %0d cycles required 32", busy); end
    n_cmp++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL mult_value: got HI=%h LO=%h required ffffffff fffffff1", hi, lo); end
    @(negedge clk);
    n_cmp++;
    if (vout !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      n_bad++; $display("FAIL mult_hold: got VO=%b HI=%h LO=%h required 0 ffffffff fffffff1", vout, hi, lo);
    end
  endtask

  task automatic test_div;
    int n;
    issue(4'd14, 32'hFFFF_FFF9, 32'd2);
    wait_vo(n);
    n_cmp++;
    if (n != 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || dbz !== 1'b0) begin
      n_bad++; $display("FAIL div_signed: got n=%0d LO=%h HI=%h DBZ=%b required 33 fffffffd ffffffff 0", n, lo, hi, dbz);
    end
    issue(4'd13, 32'd7, 32'd0);
    wait_vo(n);
    n_cmp++;
    if (n != 33 || lo !== 32'hFFFF_FFFF || hi !== 32'd7 || dbz !== 1'b1) begin
      n_bad++; $display("FAIL divu_by_zero: got n=%0d LO=%h HI=%h DBZ=%b required 33 ffffffff 00000007 1", n, lo, hi, dbz);
    end
    issue(4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_vo(n);
    n_cmp++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0 || dbz !== 1'b0) begin
      n_bad++; $display("FAIL div_most_neg: got LO=%h HI=%h DBZ=%b required 80000000 0 0", lo, hi, dbz);
    end
    issue(4'd14, 32'hFFFF_FFF7, 32'd0);
    wait_vo(n);
    n_cmp++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF7 || dbz !== 1'b1) begin
      n_bad++; $display("FAIL div_signed_by_zero: got LO=%h HI=%h DBZ=%b required ffffffff fffffff7 1", lo, hi, dbz);
    end
    issue(4'd7, 32'd5, 32'd3);
    wait_vo(n);
    n_cmp++;
    if (n != 1 || dbz !== 1'b0 || result !== 32'd6 || hi !== 32'hFFFF_FFF7 || lo !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL dbz_clear_hilo_keep: got n=%0d DBZ=%b RES=%h HI=%h LO=%h required 1 0 6 fffffff7 ffffffff", n, dbz, result, hi, lo);
    end
    issue(4'd15, 32'h1234, 32'h5678);
    wait_vo(n);
    n_cmp++;
    if (n != 1 || result !== 32'd0 || zero !== 1'b1) begin
      n_bad++; $display("FAIL reserved_op: got n=%0d RES=%h Z=%b required 1 0 1", n, result, zero);
    end
  endtask

  task automatic test_reset_abort;
    int n;
    int pulses;
    pulses = 0;
    valid_in = 1'b1; opcode = 4'd11; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready_in_reset: got %b required 0", ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    n_cmp++;
    if ({vout, result, zero, ovf, dbz, hi, lo} !== '0 || ready !== 1'b1) begin
      n_bad++; $display("FAIL abort_outputs: got VO=%b RES=%h HI=%h LO=%h flags=%b%b%b READY=%b required all 0, READY 1", vout, result, hi, lo, zero, ovf, dbz, ready);
    end
    repeat (40) begin
      @(negedge clk);
      if (vout === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin n_bad++; $display("FAIL abort_no_valid: got %0d pulses required 0", pulses); end
    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_vo(n);
    n_cmp++;
    if (n != 33 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      n_bad++; $display("FAIL multu_after_abort: got n=%0d HI=%h LO=%h required 33 fffffffe 00000001", n, hi, lo);
    end
  endtask

  task automatic test_busy_hold;
    int          n;
    logic [63:0] p;
    n = -1;
    p = 64'h1234_5678 * 64'h9ABC_DEF0;
    push_exp(4'd11, 32'h1234_5678, 32'h9ABC_DEF0);
    push_exp(4'd3, 32'h10, 32'h20);
    valid_in = 1'b1; opcode = 4'd11; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    opcode = 4'd3; a = 32'h10; b = 32'h20;
    for (int i = 1; i <= 100 && n < 0; i++) begin
      @(negedge clk);
      if (vout === 1'b1) n = i;
    end
    n_cmp++;
    if (n != 33 || ready !== 1'b1) begin n_bad++; $display("FAIL busy_hold_done: got n=%0d READY=%b required 33 1", n, ready); end
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (vout !== 1'b1 || result !== 32'h30 || hi !== p[63:32] || lo !== p[31:0]) begin
      n_bad++; $display("FAIL accept_in_done: got VO=%b RES=%h HI=%h LO=%h required 1 00000030 %h %h", vout, result, hi, lo, p[63:32], p[31:0]);
    end
    @(negedge clk);
    n_cmp++;
    if (vout !== 1'b0) begin n_bad++; $display("FAIL accept_in_done_pulse: got VO=%b required 0", vout); end
  endtask

  task automatic test_random;
    int           n;
    int           lat;
    logic [3:0]   op;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    for (int k = 0; k < 30; k++) begin
      op = 4'($urandom_range(0, 15));
      av = $urandom;
      bv = $urandom;
      if (k % 5 == 0) bv = '0;
      if (k % 7 == 0) av = 32'h8000_0000;
      if (k % 9 == 0) bv = 32'hFFFF_FFFF;
      lat = (op >= 4'd11 && op <= 4'd14) ? 33 : 1;
      issue(op, av, bv);
      wait_vo(n);
      n_cmp++;
      if (n != lat) begin n_bad++; $display("FAIL random_latency op=%0d: got %0d required %0d", op, n, lat); end
    end
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; opcode = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    test_reset();
    test_shift();
    test_addsub();
    test_mult();
    test_div();
    test_reset_abort();
    test_busy_hold();
    test_random();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (scb.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d pending required 0", scb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
